// File: rtl/arith_pkg.sv
// Opcode encodings and write-back FSM state type, shared by the arithmetic
// unit, the decoder and the write-back stage.
package arith_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_MUL = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } wb_state_t;

endpackage

// File: rtl/arith_wb.sv
// Result write-back stage: captures arithmetic results and drives the 16-bit
// register-file write port, splitting MUL results over two consecutive writes.
//
// state | meaning
// IDLE  | no write pending, ready for a new result
// WR_LO | writing result[15:0] to dest
// WR_HI | writing MUL result[31:16] to dest+1 (wraps)
module arith_wb
  import arith_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_result,
  input  logic [2:0]        in_opcode,
  input  logic [REG_AW-1:0] in_dest,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              zero_flag,
  output logic              hi_flag,
  output logic              err
);

  wb_state_t         r_state;
  wb_state_t         w_state_nxt;
  logic [31:0]       r_result;
  logic [2:0]        r_opcode;
  logic [REG_AW-1:0] r_dest;
  logic              r_zero;
  logic              r_hi;
  logic              r_err;

  logic              w_accept;
  logic              w_legal;
  logic              w_in_mul;
  logic [REG_AW-1:0] w_dest_hi;

  assign w_accept  = in_valid && in_ready;
  assign w_legal   = (in_opcode[2] == 1'b0);
  assign w_in_mul  = (in_opcode == OP_MUL);
  assign w_dest_hi = r_dest + {{(REG_AW-1){1'b0}}, 1'b1};

  // Ready is a pure state decode so upstream never sees a valid->ready loop.
  assign in_ready = (r_state == IDLE) || (r_state == WR_HI) ||
                    ((r_state == WR_LO) && (r_opcode != OP_MUL));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_result <= '0;
      r_opcode <= '0;
      r_dest   <= '0;
      r_zero   <= 1'b0;
      r_hi     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_accept && !w_legal;
      if (w_accept) begin
        r_result <= in_result;
        r_opcode <= in_opcode;
        r_dest   <= in_dest;
      end
      if (w_accept && w_legal) begin
        r_zero <= w_in_mul ? (in_result == 32'd0) : (in_result[15:0] == 16'd0);
        r_hi   <= w_in_mul && (in_result[31:16] != 16'd0);
      end
    end
  end

  always_comb begin
    w_state_nxt = IDLE;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    if (w_accept && w_legal) begin
      w_state_nxt = WR_LO;
    end
    case (r_state)
      WR_LO: begin
        wr_en   = 1'b1;
        wr_addr = r_dest;
        wr_data = r_result[15:0];
        if (r_opcode == OP_MUL) begin
          w_state_nxt = WR_HI;
        end
      end
      WR_HI: begin
        wr_en   = 1'b1;
        wr_addr = w_dest_hi;
        wr_data = r_result[31:16];
      end
      default: ;
    endcase
  end

  assign zero_flag = r_zero;
  assign hi_flag   = r_hi;
  assign err       = r_err;

endmodule

// File: tb/tb_arith_wb.sv
// Self-checking bench for arith_wb: vector table plus hand sequences, with a
// write scoreboard fed at stimulus time and drained by a write-port monitor.
module tb_arith_wb;
  import arith_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [2:0]  in_opcode;
  logic [3:0]  in_dest;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        zero_flag;
  logic        hi_flag;
  logic        err;

  arith_wb #(.REG_AW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_result (in_result),
    .in_opcode (in_opcode),
    .in_dest   (in_dest),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .zero_flag (zero_flag),
    .hi_flag   (hi_flag),
    .err       (err)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] res;
    logic [3:0]  dest;
    logic        ez;
    logic        eh;
    logic        eerr;
  } vec_t;

  typedef struct {
    logic [3:0]  a;
    logic [15:0] d;
  } wr_t;

  vec_t vecs[10];
  wr_t  q[$];
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Call just after a negedge; returns at the accepting posedge.
  task automatic send(input logic [2:0] op, input logic [31:0] res, input logic [3:0] dest);
    int   n;
    wr_t  w;
    logic [3:0] d1;
    in_valid  = 1'b1;
    in_opcode = op;
    in_result = res;
    in_dest   = dest;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
    if (op[2] == 1'b0) begin
      w.a = dest;
      w.d = res[15:0];
      q.push_back(w);
      if (op == OP_MUL) begin
        d1  = dest + 4'd1;
        w.a = d1;
        w.d = res[31:16];
        q.push_back(w);
      end
    end
    @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        if (q.size() == 0) begin
          chk("unexpected_write", {16'd0, wr_data}, 32'hDEAD_BEEF);
        end else begin
          wr_t e;
          e = q.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(e.a));
          chk("wr_data", 32'(wr_data), 32'(e.d));
        end
      end else begin
        chk("idle_port_zero", {12'd0, wr_addr, wr_data}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3'b000, 32'h0000_0011, 4'd3,  1'b0, 1'b0, 1'b0};
    vecs[1] = '{3'b001, 32'h0001_0010, 4'd15, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{3'b000, 32'hFFFF_0000, 4'd4,  1'b1, 1'b0, 1'b0};
    vecs[3] = '{3'b101, 32'hFFFF_FFFF, 4'd6,  1'b1, 1'b0, 1'b1};
    vecs[4] = '{3'b010, 32'h0000_0000, 4'd2,  1'b1, 1'b0, 1'b0};
    vecs[5] = '{3'b001, 32'h0000_0000, 4'd5,  1'b1, 1'b0, 1'b0};
    vecs[6] = '{3'b001, 32'h0005_0000, 4'd7,  1'b0, 1'b1, 1'b0};
    vecs[7] = '{3'b111, 32'h0000_0000, 4'd0,  1'b0, 1'b1, 1'b1};
    vecs[8] = '{3'b011, 32'h1234_FFFF, 4'd14, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{3'b001, 32'h0000_FFFF, 4'd15, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0;
    in_result = '0;
    in_opcode = '0;
    in_dest = '0;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_port", {11'd0, wr_en, wr_addr, wr_data}, 32'd0);
    chk("rst_flags", {29'd0, zero_flag, hi_flag, err}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      send(vecs[i].op, vecs[i].res, vecs[i].dest);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].eerr));
      chk($sformatf("v%0d_zero", i), 32'(zero_flag), 32'(vecs[i].ez));
      chk($sformatf("v%0d_hi", i), 32'(hi_flag), 32'(vecs[i].eh));
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_err_clear", i), 32'(err), 32'd0);
      chk($sformatf("v%0d_drained", i), 32'(q.size()), 32'd0);
    end

    // Back-to-back ADD, SUB, DIV with valid held high.
    @(negedge clk);
    send(OP_ADD, 32'd5, 4'd1);
    @(negedge clk);
    chk("b2b_wr1", 32'(wr_en), 32'd1);
    chk("b2b_ready1", 32'(in_ready), 32'd1);
    chk("b2b_zero1", 32'(zero_flag), 32'd0);
    send(OP_SUB, 32'd0, 4'd2);
    @(negedge clk);
    chk("b2b_wr2", 32'(wr_en), 32'd1);
    chk("b2b_zero2", 32'(zero_flag), 32'd1);
    send(OP_DIV, 32'd2, 4'd3);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_wr3", 32'(wr_en), 32'd1);
    chk("b2b_zero3", 32'(zero_flag), 32'd0);
    @(negedge clk);
    chk("b2b_done", 32'(wr_en), 32'd0);
    chk("b2b_drained", 32'(q.size()), 32'd0);

    // MUL with wrap: ready low during the low write, high during the high write.
    @(negedge clk);
    send(OP_MUL, 32'h0001_0010, 4'd15);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("mul_lo_ready", 32'(in_ready), 32'd0);
    chk("mul_lo_wr", 32'(wr_en), 32'd1);
    chk("mul_hi_flag", 32'(hi_flag), 32'd1);
    @(negedge clk);
    chk("mul_hi_ready", 32'(in_ready), 32'd1);
    chk("mul_hi_wr", 32'(wr_en), 32'd1);
    @(negedge clk);
    chk("mul_done", 32'(wr_en), 32'd0);
    chk("mul_drained", 32'(q.size()), 32'd0);

    // Illegal opcode accepted straight out of a non-MUL low write.
    @(negedge clk);
    send(OP_ADD, 32'h0000_0000, 4'd8);
    @(negedge clk);
    send(3'b100, 32'h0000_0001, 4'd9);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("ill_b2b_err", 32'(err), 32'd1);
    chk("ill_b2b_nowr", 32'(wr_en), 32'd0);
    chk("ill_b2b_zero", 32'(zero_flag), 32'd1);
    @(negedge clk);
    chk("ill_b2b_err_clear", 32'(err), 32'd0);

    // Reset during the low write of a MUL: drop at once, no high write replayed.
    @(negedge clk);
    send(OP_MUL, 32'hABCD_1234, 4'd9);
    #1 in_valid = 1'b0;
    #1 chk("rstmid_pre_wr", 32'(wr_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_port", {11'd0, wr_en, wr_addr, wr_data}, 32'd0);
    chk("rstmid_ready", 32'(in_ready), 32'd1);
    chk("rstmid_flags", {30'd0, zero_flag, hi_flag}, 32'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rstmid_after_ready", 32'(in_ready), 32'd1);
    chk("rstmid_after_wr", 32'(wr_en), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
